// File: rtl/handshake_rr_arbiter.sv
// Round-robin, packet-locked arbiter that feeds N valid/ready masters into one
// registered full-throughput output stage and tags each beat with its source index.
module handshake_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  input  logic                      out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic              out_last_q, out_last_d;

  logic [DATA_W-1:0] data_arr [NUM_REQ];
  logic              stage_ready;
  logic              grant_en;
  logic [ID_W-1:0]   grant_id;
  logic              xfer;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Grant selection: the lock owner while mid-packet, otherwise the first valid
  // requester at or after rr_ptr. Ready is masked during reset.
  always_comb begin : arb
    int unsigned     idx;
    logic [ID_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    stage_ready = out_ready | ~out_valid_q;
    grant_en    = 1'b0;
    grant_id    = '0;
    if (state_q == LOCKED) begin
      grant_en = 1'b1;
      grant_id = lock_id_q;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = ID_W'(idx);
        if (!grant_en && req_valid[cand]) begin
          grant_en = 1'b1;
          grant_id = cand;
        end
      end
    end
    req_ready = '0;
    if (grant_en && !rst) req_ready[grant_id] = stage_ready;
    xfer = req_valid[grant_id] & req_ready[grant_id];
  end

  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = data_arr[grant_id];
      out_id_d    = grant_id;
      out_last_d  = req_last[grant_id];
      if (req_last[grant_id]) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else begin
        state_d   = LOCKED;
        lock_id_d = grant_id;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_id_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_id_q   <= lock_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Scoreboard bench for handshake_rr_arbiter: a cycle-level reference model predicts
// grants and pushes expected beats; a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_handshake_rr_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_last;
  logic                      out_ready;

  always #5 clk = ~clk;

  handshake_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_last(out_last),
    .out_ready(out_ready)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    int unsigned       gap;
  } beat_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    bit                last;
  } exp_t;

  beat_t       srcq [NUM_REQ][$];
  exp_t        sb[$];
  bit          presenting [NUM_REQ];
  int unsigned wait_cnt [NUM_REQ];
  bit          rst_v;
  int unsigned ordy_pct;

  // reference model state
  bit          m_locked;
  int unsigned m_owner;
  int unsigned m_ptr;
  bit          m_ovalid;
  bit          rst_prev;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int unsigned i, input logic [DATA_W-1:0] d,
                           input bit last, input int unsigned gap);
    beat_t b;
    b.data = d; b.last = last; b.gap = gap;
    srcq[i].push_back(b);
  endtask

  function automatic bit busy();
    bit r;
    r = (sb.size() != 0) || m_ovalid;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (srcq[i].size() != 0 || presenting[i]) r = 1'b1;
    return r;
  endfunction

  // Model step, evaluated mid-cycle with inputs stable: predict ready/valid and
  // the transfer that the next rising edge performs.
  task automatic step_model();
    logic [NUM_REQ-1:0] exp_rdy;
    bit    stage;
    int    g;
    beat_t b;
    exp_t  e;
    exp_rdy = '0;
    stage   = out_ready || !m_ovalid;
    if (!rst) begin
      if (m_locked) begin
        if (stage) exp_rdy[m_owner] = 1'b1;
      end else begin
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
          int unsigned i = (m_ptr + k) % NUM_REQ;
          if (req_valid[i]) begin
            if (stage) exp_rdy[i] = 1'b1;
            break;
          end
        end
      end
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ovalid));
    if (rst_prev) begin
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_id", 64'(out_id), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
    end
    rst_prev = rst;
    if (rst) begin
      sb.delete();
      m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_ovalid = 1'b0;
    end else begin
      g = -1;
      for (int i = 0; i < int'(NUM_REQ); i++)
        if (req_valid[i] && exp_rdy[i]) g = i;
      if (g >= 0) begin
        b = srcq[g].pop_front();
        presenting[g] = 1'b0;
        wait_cnt[g]   = 0;
        e.data = b.data; e.id = ID_W'(g); e.last = b.last;
        sb.push_back(e);
        m_ovalid = 1'b1;
        if (b.last) begin
          m_locked = 1'b0;
          m_ptr    = (int'(g) + 1) % NUM_REQ;
        end else begin
          m_locked = 1'b1;
          m_owner  = g;
        end
      end else if (m_ovalid && out_ready) begin
        m_ovalid = 1'b0;
      end
    end
  endtask

  task automatic drive();
    rst       = rst_v;
    out_ready = ($urandom_range(0, 99) < ordy_pct);
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!presenting[i] && srcq[i].size() != 0) begin
        if (wait_cnt[i] < srcq[i][0].gap) wait_cnt[i]++;
        else begin
          presenting[i] = 1'b1;
          wait_cnt[i]   = 0;
        end
      end
      req_valid[i] = presenting[i];
      if (presenting[i]) begin
        req_data[i*DATA_W +: DATA_W] = srcq[i][0].data;
        req_last[i] = srcq[i][0].last;
      end else begin
        req_data[i*DATA_W +: DATA_W] = $urandom;
        req_last[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int unsigned bound);
    int unsigned n = 0;
    run_cycle();
    while (busy() && n < bound) begin
      run_cycle();
      n++;
    end
    checks++;
    if (busy()) begin
      failures++;
      $display("FAIL drain_timeout actual=busy required=idle t=%0t", $time);
    end
  endtask

  // Monitor: whenever the output stage holds a beat it must match the oldest
  // expected beat; it is retired when downstream accepts it.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat actual=data %0h id %0d required=none", out_data, out_id);
      end else begin
        e = sb[0];
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_id", 64'(out_id), 64'(e.id));
        chk("out_last", 64'(out_last), 64'(e.last));
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  initial begin
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_ovalid = 1'b0; rst_prev = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      presenting[i] = 1'b0;
      wait_cnt[i]   = 0;
    end

    // Reset with all requesters valid, then round-robin over single-beat packets
    rst_v = 1'b1; ordy_pct = 100;
    for (int unsigned n = 0; n < 3; n++)
      for (int unsigned i = 0; i < NUM_REQ; i++)
        push_beat(i, 32'hA0 + i, 1'b1, 0);
    drive();
    run_cycle();
    rst_v = 1'b0;
    run_cycle();
    drain(200);

    // Packet lock: req0 three beats, req1 single beat waiting throughout
    push_beat(0, 32'h10, 1'b0, 0);
    push_beat(0, 32'h11, 1'b0, 0);
    push_beat(0, 32'h12, 1'b1, 0);
    push_beat(1, 32'h20, 1'b1, 0);
    drain(200);

    // Backpressure: 0x55 from req2 held for 5 cycles, req3 queued behind it
    ordy_pct = 0;
    push_beat(2, 32'h55, 1'b1, 0);
    push_beat(3, 32'h66, 1'b1, 0);
    run_cycle();
    run_cycle();
    for (int unsigned n = 0; n < 5; n++) run_cycle();
    ordy_pct = 100;
    drain(200);

    // Locked owner stall: req3 drops valid mid-packet while req1 waits
    push_beat(3, 32'h30, 1'b0, 0);
    push_beat(3, 32'h31, 1'b1, 4);
    push_beat(1, 32'h40, 1'b1, 1);
    drain(200);

    // Reset mid-packet: lock on req2, reset for one cycle, req0 then wins
    push_beat(2, 32'h70, 1'b0, 0);
    push_beat(2, 32'h71, 1'b1, 0);
    push_beat(0, 32'h80, 1'b1, 1);
    run_cycle();
    rst_v = 1'b1;
    run_cycle();
    rst_v = 1'b0;
    run_cycle();
    drain(200);

    // Random packets, gaps and backpressure, with one reset in the middle
    ordy_pct = 70;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      for (int unsigned p = 0; p < 6; p++) begin
        int unsigned len = $urandom_range(1, 4);
        for (int unsigned b = 0; b < len; b++)
          push_beat(i, $urandom, (b == len - 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    for (int unsigned n = 0; n < 40; n++) run_cycle();
    rst_v = 1'b1;
    run_cycle();
    rst_v = 1'b0;
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
